// File: rtl/fust_m_issue_ctrl_pkg.sv
// Shared types for the matrix FU status-table issue controller.
// Holds the FSM encoding, the latched row layout and the tag wakeup rule.
package fust_m_issue_ctrl_pkg;

    localparam int MREG_W = 4;
    localparam int TAG_W  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4
    } fust_m_ctrl_state_t;

    typedef struct packed {
        logic [MREG_W-1:0] md;
        logic [MREG_W-1:0] ms1;
        logic [MREG_W-1:0] ms2;
        logic [MREG_W-1:0] ms3;
        logic [TAG_W-1:0]  t1;
        logic [TAG_W-1:0]  t2;
        logic [TAG_W-1:0]  t3;
        logic              spec;
    } fust_m_ctrl_row_t;

    // A zero tag already means "ready", so it can never be woken by a broadcast.
    function automatic logic [TAG_W-1:0] wake_tag(input logic [TAG_W-1:0] tag,
                                                  input logic             valid,
                                                  input logic [TAG_W-1:0] wtag);
        return (valid && (tag != '0) && (tag == wtag)) ? '0 : tag;
    endfunction

endpackage

// File: rtl/fust_m_issue_ctrl_mm_lat_counter.sv
// Down-counter timing the matrix unit latency; loads MM_LAT-1 on start
// and saturates at zero so it never wraps.
module mm_lat_counter #(
    parameter int MM_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic dec,
    output logic zero,
    output logic last
);

    localparam int CNT_W = $clog2(MM_LAT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MM_LAT - 1);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/fust_m_issue_ctrl.sv
// Single-row matrix FUST issue controller: captures one dispatched op, wakes its
// tags, issues to the MAC unit, times execution and arbitrates for writeback.
module fust_m_issue_ctrl
    import fust_m_issue_ctrl_pkg::*;
#(
    parameter int MM_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_en,
    input  logic [MREG_W-1:0]  disp_md,
    input  logic [MREG_W-1:0]  disp_ms1,
    input  logic [MREG_W-1:0]  disp_ms2,
    input  logic [MREG_W-1:0]  disp_ms3,
    input  logic [TAG_W-1:0]   disp_t1,
    input  logic [TAG_W-1:0]   disp_t2,
    input  logic [TAG_W-1:0]   disp_t3,
    input  logic               disp_spec,
    input  logic               wkup_valid,
    input  logic [TAG_W-1:0]   wkup_tag,
    input  logic               flush,
    input  logic               resolved,
    output logic               busy,
    input  logic               mm_ready,
    output logic               mm_start,
    output logic [MREG_W-1:0]  mm_ms1,
    output logic [MREG_W-1:0]  mm_ms2,
    output logic [MREG_W-1:0]  mm_ms3,
    output logic               wb_req,
    output logic [MREG_W-1:0]  wb_md,
    input  logic               wb_gnt,
    output fust_m_ctrl_state_t dbg_state
);

    fust_m_ctrl_state_t state, next_state;
    fust_m_ctrl_row_t   row;
    logic               squash;
    logic [TAG_W-1:0]   w1, w2, w3;
    logic               tags_ready;
    logic               cnt_zero, cnt_last;

    // In IDLE the incoming op is the one a flush can squash; afterwards it is the latched one.
    always_comb begin
        squash     = flush && ((state == IDLE) ? (disp_en && disp_spec) : row.spec);
        w1         = wake_tag((state == IDLE) ? disp_t1 : row.t1, wkup_valid, wkup_tag);
        w2         = wake_tag((state == IDLE) ? disp_t2 : row.t2, wkup_valid, wkup_tag);
        w3         = wake_tag((state == IDLE) ? disp_t3 : row.t3, wkup_valid, wkup_tag);
        tags_ready = ((w1 | w2 | w3) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (disp_en && !squash) next_state = WAIT;
            WAIT:    if (squash) next_state = IDLE;
                     else if (tags_ready) next_state = ISSUE;
            ISSUE:   if (squash) next_state = IDLE;
                     else if (mm_ready) next_state = EXEC;
            EXEC:    if (squash) next_state = IDLE;
                     else if (cnt_last || cnt_zero) next_state = WB;
            WB:      if (squash) next_state = IDLE;
                     else if (wb_req && wb_gnt) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mm_start  = (state == ISSUE) && mm_ready;
        wb_req    = (state == WB) && !row.spec;
        mm_ms1    = row.ms1;
        mm_ms2    = row.ms2;
        mm_ms3    = row.ms3;
        wb_md     = row.md;
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if (state == IDLE) begin
            if (disp_en && !squash) begin
                row <= '{md: disp_md, ms1: disp_ms1, ms2: disp_ms2, ms3: disp_ms3,
                         t1: w1, t2: w2, t3: w3, spec: disp_spec};
            end
        end else begin
            row.t1 <= w1;
            row.t2 <= w2;
            row.t3 <= w3;
            if (resolved && !squash) row.spec <= 1'b0;
        end
    end

    // Exit EXEC on the edge the count reaches zero so WB lands MM_LAT cycles after start.
    mm_lat_counter #(.MM_LAT(MM_LAT)) u_lat (
        .clk   (clk),
        .rst   (rst),
        .load  (mm_start && !squash),
        .clear (squash),
        .dec   (state == EXEC),
        .zero  (cnt_zero),
        .last  (cnt_last)
    );

endmodule

// File: tb/tb_fust_m_issue_ctrl.sv
// Directed bench for the matrix FUST issue controller: cycle-indexed expectations
// for issue timing, wakeup, speculation, flush, stalls and reset.
module tb_fust_m_issue_ctrl;
    import fust_m_issue_ctrl_pkg::*;

    localparam int LAT = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               disp_en;
    logic [MREG_W-1:0]  disp_md, disp_ms1, disp_ms2, disp_ms3;
    logic [TAG_W-1:0]   disp_t1, disp_t2, disp_t3;
    logic               disp_spec;
    logic               wkup_valid;
    logic [TAG_W-1:0]   wkup_tag;
    logic               flush, resolved;
    logic               busy;
    logic               mm_ready;
    logic               mm_start;
    logic [MREG_W-1:0]  mm_ms1, mm_ms2, mm_ms3;
    logic               wb_req;
    logic [MREG_W-1:0]  wb_md;
    logic               wb_gnt;
    fust_m_ctrl_state_t dbg_state;

    int vectors = 0;
    int miscompares = 0;

    fust_m_issue_ctrl #(.MM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .disp_en(disp_en), .disp_md(disp_md),
        .disp_ms1(disp_ms1), .disp_ms2(disp_ms2), .disp_ms3(disp_ms3),
        .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_t3(disp_t3),
        .disp_spec(disp_spec), .wkup_valid(wkup_valid), .wkup_tag(wkup_tag),
        .flush(flush), .resolved(resolved), .busy(busy), .mm_ready(mm_ready),
        .mm_start(mm_start), .mm_ms1(mm_ms1), .mm_ms2(mm_ms2), .mm_ms3(mm_ms3),
        .wb_req(wb_req), .wb_md(wb_md), .wb_gnt(wb_gnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Dispatch must stall while the row is occupied.
    always @(posedge clk) begin
        if (!rst && disp_en && busy) begin
            miscompares++;
            $display("FAIL disp_while_busy t=%0t got disp_en=1 busy=1 exp no dispatch", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        disp_en = 0; disp_md = 0; disp_ms1 = 0; disp_ms2 = 0; disp_ms3 = 0;
        disp_t1 = 0; disp_t2 = 0; disp_t3 = 0; disp_spec = 0;
        wkup_valid = 0; wkup_tag = 0; flush = 0; resolved = 0;
        mm_ready = 1; wb_gnt = 1;
    endtask

    task automatic set_op(input logic [MREG_W-1:0] md, input logic [MREG_W-1:0] s1,
                          input logic [MREG_W-1:0] s2, input logic [MREG_W-1:0] s3,
                          input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                          input logic [TAG_W-1:0] t3, input logic spec);
        disp_md = md; disp_ms1 = s1; disp_ms2 = s2; disp_ms3 = s3;
        disp_t1 = t1; disp_t2 = t2; disp_t3 = t3; disp_spec = spec;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({busy, mm_start, wb_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctl got busy/start/req=%b%b%b exp 000", busy, mm_start, wb_req);
        end
        vectors++;
        if ({mm_ms1, mm_ms2, mm_ms3, wb_md} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields got ms=%h/%h/%h md=%h exp 0", mm_ms1, mm_ms2, mm_ms3, wb_md);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_busy, exp_start, exp_req;
        clear_inputs();
        for (int c = 0; c <= LAT + 3; c++) begin
            disp_en = (c == 0);
            if (c == 0) set_op(4'd4, 4'd1, 4'd2, 4'd3, 2'd0, 2'd0, 2'd0, 1'b0);
            #1;
            exp_busy  = (c >= 1 && c <= LAT + 2);
            exp_start = (c == 2);
            exp_req   = (c == LAT + 2);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            vectors++;
            if (mm_start !== exp_start) begin
                miscompares++;
                $display("FAIL basic_start c=%0d got %b exp %b", c, mm_start, exp_start);
            end
            vectors++;
            if (wb_req !== exp_req) begin
                miscompares++;
                $display("FAIL basic_wb_req c=%0d got %b exp %b", c, wb_req, exp_req);
            end
            if (c == 2) begin
                vectors++;
                if ({mm_ms1, mm_ms2, mm_ms3} !== {4'd1, 4'd2, 4'd3}) begin
                    miscompares++;
                    $display("FAIL basic_srcs got %0d/%0d/%0d exp 1/2/3", mm_ms1, mm_ms2, mm_ms3);
                end
            end
            if (c == LAT + 2) begin
                vectors++;
                if (wb_md !== 4'd4) begin
                    miscompares++;
                    $display("FAIL basic_wb_md got %0d exp 4", wb_md);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wakeup();
        logic exp_busy, exp_start, exp_req;
        clear_inputs();
        for (int c = 0; c <= LAT + 7; c++) begin
            disp_en = (c == 0);
            if (c == 0) set_op(4'd5, 4'd6, 4'd7, 4'd8, 2'd1, 2'd0, 2'd2, 1'b0);
            // tag 0 broadcast, invalid tag2, tag1, unrelated tag3, then tag2
            wkup_valid = (c == 1) || (c == 3) || (c == 4) || (c == 5);
            case (c)
                1:       wkup_tag = 2'd0;
                2:       wkup_tag = 2'd2;
                3:       wkup_tag = 2'd1;
                4:       wkup_tag = 2'd3;
                5:       wkup_tag = 2'd2;
                default: wkup_tag = 2'd0;
            endcase
            #1;
            exp_busy  = (c >= 1 && c <= LAT + 6);
            exp_start = (c == 6);
            exp_req   = (c == LAT + 6);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL wkup_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            vectors++;
            if (mm_start !== exp_start) begin
                miscompares++;
                $display("FAIL wkup_start c=%0d got %b exp %b", c, mm_start, exp_start);
            end
            vectors++;
            if (wb_req !== exp_req) begin
                miscompares++;
                $display("FAIL wkup_wb_req c=%0d got %b exp %b", c, wb_req, exp_req);
            end
            if (c == 5) begin
                vectors++;
                if (dbg_state !== WAIT) begin
                    miscompares++;
                    $display("FAIL wkup_state c=5 got %0d exp %0d", dbg_state, WAIT);
                end
            end
            if (c == 6) begin
                vectors++;
                if ({mm_ms1, mm_ms2, mm_ms3} !== {4'd6, 4'd7, 4'd8}) begin
                    miscompares++;
                    $display("FAIL wkup_srcs got %0d/%0d/%0d exp 6/7/8", mm_ms1, mm_ms2, mm_ms3);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_same_cycle_wkup();
        logic exp_busy, exp_start, exp_req;
        clear_inputs();
        for (int c = 0; c <= LAT + 3; c++) begin
            disp_en    = (c == 0);
            wkup_valid = (c == 0);
            wkup_tag   = 2'd1;
            if (c == 0) set_op(4'd11, 4'd12, 4'd13, 4'd14, 2'd1, 2'd0, 2'd0, 1'b0);
            #1;
            exp_busy  = (c >= 1 && c <= LAT + 2);
            exp_start = (c == 2);
            exp_req   = (c == LAT + 2);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL same_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            vectors++;
            if (mm_start !== exp_start) begin
                miscompares++;
                $display("FAIL same_start c=%0d got %b exp %b", c, mm_start, exp_start);
            end
            vectors++;
            if (wb_req !== exp_req) begin
                miscompares++;
                $display("FAIL same_wb_req c=%0d got %b exp %b", c, wb_req, exp_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_spec_resolve();
        logic exp_busy, exp_req, exp_wb;
        clear_inputs();
        for (int c = 0; c <= LAT + 7; c++) begin
            disp_en  = (c == 0);
            resolved = (c == LAT + 5);
            if (c == 0) set_op(4'd7, 4'd1, 4'd1, 4'd1, 2'd0, 2'd0, 2'd0, 1'b1);
            #1;
            exp_busy = (c >= 1 && c <= LAT + 6);
            exp_req  = (c == LAT + 6);
            exp_wb   = (c >= LAT + 2 && c <= LAT + 6);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL spec_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            vectors++;
            if (wb_req !== exp_req) begin
                miscompares++;
                $display("FAIL spec_wb_req c=%0d got %b exp %b", c, wb_req, exp_req);
            end
            vectors++;
            if ((dbg_state == WB) !== exp_wb) begin
                miscompares++;
                $display("FAIL spec_in_wb c=%0d got state %0d exp in_wb=%b", c, dbg_state, exp_wb);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        logic exp_busy, exp_start, exp_req;
        logic squashed;
        for (int m = 0; m < 3; m++) begin
            clear_inputs();
            squashed = (m < 2);
            for (int c = 0; c <= LAT + 3; c++) begin
                disp_en  = (c == 0);
                flush    = (c == 5);
                resolved = (c == 5) && (m == 1);
                if (c == 0) set_op(4'd9, 4'd2, 4'd3, 4'd4, 2'd0, 2'd0, 2'd0, (m != 2));
                #1;
                exp_busy  = (c >= 1) && (c <= (squashed ? 5 : LAT + 2));
                exp_start = (c == 2);
                exp_req   = !squashed && (c == LAT + 2);
                vectors++;
                if (busy !== exp_busy) begin
                    miscompares++;
                    $display("FAIL flush_busy m=%0d c=%0d got %b exp %b", m, c, busy, exp_busy);
                end
                vectors++;
                if (mm_start !== exp_start) begin
                    miscompares++;
                    $display("FAIL flush_start m=%0d c=%0d got %b exp %b", m, c, mm_start, exp_start);
                end
                vectors++;
                if (wb_req !== exp_req) begin
                    miscompares++;
                    $display("FAIL flush_wb_req m=%0d c=%0d got %b exp %b", m, c, wb_req, exp_req);
                end
                @(negedge clk);
            end
        end
        // A speculative dispatch flushed in its own cycle never occupies the row.
        clear_inputs();
        disp_en = 1;
        flush   = 1;
        set_op(4'd3, 4'd3, 4'd3, 4'd3, 2'd0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_disp got busy=%b exp 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_mm_ready_and_reset();
        logic exp_start;
        clear_inputs();
        for (int c = 0; c <= 8; c++) begin
            disp_en  = (c == 0);
            mm_ready = !(c >= 2 && c <= 5);
            if (c == 0) set_op(4'd6, 4'd5, 4'd4, 4'd3, 2'd0, 2'd0, 2'd0, 1'b0);
            #1;
            exp_start = (c == 6);
            vectors++;
            if (mm_start !== exp_start) begin
                miscompares++;
                $display("FAIL stall_start c=%0d got %b exp %b", c, mm_start, exp_start);
            end
            @(negedge clk);
        end
        // now mid-EXEC: reset must clear everything without waiting for a clock edge
        #1;
        vectors++;
        if (dbg_state !== EXEC) begin
            miscompares++;
            $display("FAIL rst_pre_state got %0d exp %0d", dbg_state, EXEC);
        end
        rst = 1;
        #1;
        vectors++;
        if ({busy, mm_start, wb_req, mm_ms1, wb_md} !== '0) begin
            miscompares++;
            $display("FAIL rst_exec got busy=%b start=%b req=%b ms1=%0d md=%0d exp all 0",
                     busy, mm_start, wb_req, mm_ms1, wb_md);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // reset while waiting for the writeback grant
        clear_inputs();
        wb_gnt = 0;
        for (int c = 0; c <= LAT + 2; c++) begin
            disp_en = (c == 0);
            if (c == 0) set_op(4'd12, 4'd1, 4'd2, 4'd3, 2'd0, 2'd0, 2'd0, 1'b0);
            @(negedge clk);
        end
        #1;
        vectors++;
        if (wb_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wb_pre got wb_req=%b exp 1", wb_req);
        end
        rst = 1;
        #1;
        vectors++;
        if ({busy, wb_req, wb_md} !== '0) begin
            miscompares++;
            $display("FAIL rst_wb got busy=%b req=%b md=%0d exp all 0", busy, wb_req, wb_md);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // reset while a start pulse is being driven
        clear_inputs();
        disp_en = 1;
        set_op(4'd1, 4'd1, 4'd1, 4'd1, 2'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        disp_en = 0;
        @(negedge clk);
        #1;
        vectors++;
        if (mm_start !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_issue_pre got mm_start=%b exp 1", mm_start);
        end
        rst = 1;
        #1;
        vectors++;
        if (mm_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_issue got mm_start=%b exp 0", mm_start);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_start, exp_req;
        logic [MREG_W-1:0] exp_md;
        clear_inputs();
        for (int c = 0; c <= 2 * LAT + 8; c++) begin
            disp_en = (c == 0) || (c == LAT + 5);
            wb_gnt  = (c >= LAT + 4);
            if (c == 0)       set_op(4'd4, 4'd1, 4'd2, 4'd3, 2'd0, 2'd0, 2'd0, 1'b0);
            if (c == LAT + 5) set_op(4'd9, 4'd10, 4'd11, 4'd12, 2'd0, 2'd0, 2'd0, 1'b0);
            #1;
            exp_busy  = (c >= 1 && c <= LAT + 4) || (c >= LAT + 6 && c <= 2 * LAT + 7);
            exp_start = (c == 2) || (c == LAT + 7);
            exp_req   = (c >= LAT + 2 && c <= LAT + 4) || (c == 2 * LAT + 7);
            exp_md    = (c <= LAT + 4) ? 4'd4 : 4'd9;
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, exp_busy);
            end
            vectors++;
            if (mm_start !== exp_start) begin
                miscompares++;
                $display("FAIL b2b_start c=%0d got %b exp %b", c, mm_start, exp_start);
            end
            vectors++;
            if (wb_req !== exp_req) begin
                miscompares++;
                $display("FAIL b2b_wb_req c=%0d got %b exp %b", c, wb_req, exp_req);
            end
            if (exp_req) begin
                vectors++;
                if (wb_md !== exp_md) begin
                    miscompares++;
                    $display("FAIL b2b_wb_md c=%0d got %0d exp %0d", c, wb_md, exp_md);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_same_cycle_wkup();
        test_spec_resolve();
        test_flush();
        test_mm_ready_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
